// File: rtl/lbuf_rd_timing_gen.sv
// Output raster timing and line-buffer read sequencer in the PCLK_ext domain.
// Define FRAMELOCK_EN to lock the output raster to the input frame_sync pulse.
module lbuf_rd_timing_gen #(
  parameter int H_TOTAL          = 1650,
  parameter int H_ACTIVE         = 1280,
  parameter int H_SYNCLEN        = 40,
  parameter int H_BACKPORCH      = 220,
  parameter int V_TOTAL          = 750,
  parameter int V_ACTIVE         = 720,
  parameter int V_SYNCLEN        = 5,
  parameter int V_BACKPORCH      = 20,
  parameter int SRC_H_ACTIVE     = 384,
  parameter int SRC_V_ACTIVE     = 224,
  parameter int X_REP            = 3,
  parameter int Y_REP            = 3,
  parameter int H_IMG_START      = 324,
  parameter int V_IMG_START      = 49,
  parameter int NUM_LINE_BUFFERS = 40,
  parameter int V_LOCK_LINE      = 0
) (
  input  logic        PCLK_ext,
  input  logic        reset_n,
  input  logic        frame_sync,
  output logic [10:0] hcnt_ext,
  output logic [10:0] vcnt_ext,
  output logic [8:0]  hcnt_ext_lbuf,
  output logic [5:0]  vcnt_ext_lbuf,
  output logic [2:0]  hctr_ext,
  output logic [2:0]  vctr_ext,
  output logic        HSYNC_ext,
  output logic        VSYNC_ext,
  output logic        DE_ext,
  output logic        img_en,
  output logic        locked
);
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_SYNC  = 11'(H_SYNCLEN);
  localparam logic [10:0] V_SYNC  = 11'(V_SYNCLEN);
  localparam logic [10:0] H_DE_S  = 11'(H_SYNCLEN + H_BACKPORCH);
  localparam logic [10:0] H_DE_E  = 11'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
  localparam logic [10:0] V_DE_S  = 11'(V_SYNCLEN + V_BACKPORCH);
  localparam logic [10:0] V_DE_E  = 11'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);
  localparam logic [10:0] H_IMG_S = 11'(H_IMG_START);
  localparam logic [10:0] H_IMG_E = 11'(H_IMG_START + X_REP * SRC_H_ACTIVE);
  localparam logic [10:0] V_IMG_S = 11'(V_IMG_START);
  localparam logic [10:0] V_IMG_E = 11'(V_IMG_START + Y_REP * SRC_V_ACTIVE);
  localparam logic [2:0]  X_LAST  = 3'(X_REP - 1);
  localparam logic [2:0]  Y_LAST  = 3'(Y_REP - 1);
  localparam logic [5:0]  LB_LAST = 6'(NUM_LINE_BUFFERS - 1);

  logic [10:0] hpos, vpos;
  logic [10:0] h_nxt, v_nxt, v_nat;
  logic        h_wrap, h_img, v_img, img_nxt, locked_nxt;
  logic [2:0]  hctr_nxt, vctr_nxt;
  logic [8:0]  hlb_nxt;
  logic [5:0]  vlb_nxt;

`ifdef FRAMELOCK_EN
  localparam logic [10:0] V_LOCK = 11'(V_LOCK_LINE);
  logic pend, pend_nxt;
`else
  localparam int unused_lock_line = V_LOCK_LINE;
  logic unused_frame_sync;
  assign unused_frame_sync = frame_sync;
`endif

  always_comb begin
    h_wrap = (hpos == H_LAST);
    h_nxt  = h_wrap ? 11'd0 : hpos + 11'd1;
    v_nat  = (vpos == V_LAST) ? 11'd0 : vpos + 11'd1;
    v_nxt  = h_wrap ? v_nat : vpos;
`ifdef FRAMELOCK_EN
    // A pulse arriving on the wrap cycle itself is folded into this load.
    pend_nxt   = pend | frame_sync;
    locked_nxt = locked;
    if (h_wrap && pend_nxt) begin
      v_nxt      = V_LOCK;
      pend_nxt   = 1'b0;
      locked_nxt = (v_nat == V_LOCK);
    end
`else
    locked_nxt = 1'b0;
`endif

    h_img   = (h_nxt >= H_IMG_S) && (h_nxt < H_IMG_E);
    v_img   = (v_nxt >= V_IMG_S) && (v_nxt < V_IMG_E);
    img_nxt = h_img && v_img;

    hctr_nxt = 3'd0;
    hlb_nxt  = 9'd0;
    if (img_nxt && (h_nxt != H_IMG_S)) begin
      if (hctr_ext == X_LAST) begin
        hlb_nxt = hcnt_ext_lbuf + 9'd1;
      end else begin
        hctr_nxt = hctr_ext + 3'd1;
        hlb_nxt  = hcnt_ext_lbuf;
      end
    end

    // Vertical read position is decided once per line and held across it.
    vctr_nxt = vctr_ext;
    vlb_nxt  = vcnt_ext_lbuf;
    if (h_nxt == 11'd0) begin
      vctr_nxt = 3'd0;
      vlb_nxt  = 6'd0;
      if (v_img && (v_nxt != V_IMG_S)) begin
        if (vctr_ext == Y_LAST) begin
          vlb_nxt = (vcnt_ext_lbuf == LB_LAST) ? 6'd0 : vcnt_ext_lbuf + 6'd1;
        end else begin
          vctr_nxt = vctr_ext + 3'd1;
          vlb_nxt  = vcnt_ext_lbuf;
        end
      end
    end
  end

  always_ff @(posedge PCLK_ext or negedge reset_n) begin
    if (!reset_n) begin
      hpos          <= H_LAST;
      vpos          <= V_LAST;
      hcnt_ext      <= '0;
      vcnt_ext      <= '0;
      hcnt_ext_lbuf <= '0;
      vcnt_ext_lbuf <= '0;
      hctr_ext      <= '0;
      vctr_ext      <= '0;
      HSYNC_ext     <= 1'b1;
      VSYNC_ext     <= 1'b1;
      DE_ext        <= 1'b0;
      img_en        <= 1'b0;
      locked        <= 1'b0;
`ifdef FRAMELOCK_EN
      pend          <= 1'b0;
`endif
    end else begin
      hpos          <= h_nxt;
      vpos          <= v_nxt;
      hcnt_ext      <= h_nxt;
      vcnt_ext      <= v_nxt;
      hcnt_ext_lbuf <= hlb_nxt;
      vcnt_ext_lbuf <= vlb_nxt;
      hctr_ext      <= hctr_nxt;
      vctr_ext      <= vctr_nxt;
      HSYNC_ext     <= !(h_nxt < H_SYNC);
      VSYNC_ext     <= !(v_nxt < V_SYNC);
      DE_ext        <= (h_nxt >= H_DE_S) && (h_nxt < H_DE_E) &&
                       (v_nxt >= V_DE_S) && (v_nxt < V_DE_E);
      img_en        <= img_nxt;
      locked        <= locked_nxt;
`ifdef FRAMELOCK_EN
      pend          <= pend_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_lbuf_rd_timing_gen.sv
// Bench for lbuf_rd_timing_gen on a reduced raster, checked against an arithmetic position model.
// Expectations follow FRAMELOCK_EN when it is defined for the build.
module tb_lbuf_rd_timing_gen;
  localparam int HT = 60, HA = 40, HSL = 4, HBP = 8;
  localparam int VT = 40, VA = 30, VSL = 2, VBP = 4;
  localparam int SH = 10, SV = 9, XR = 3, YR = 3;
  localparam int HIS = 15, VIS = 8, NLB = 4, VLK = 0;
`ifdef FRAMELOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic        PCLK_ext = 1'b0;
  logic        reset_n, frame_sync;
  logic [10:0] hcnt_ext, vcnt_ext;
  logic [8:0]  hcnt_ext_lbuf;
  logic [5:0]  vcnt_ext_lbuf;
  logic [2:0]  hctr_ext, vctr_ext;
  logic        HSYNC_ext, VSYNC_ext, DE_ext, img_en, locked;

  int n_tests = 0, n_fail = 0;
  int mh, mv, cyc = 0, c0;
  bit mpend, mlocked;
  int de_cnt, img_cnt, hs_cnt;

  lbuf_rd_timing_gen #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNCLEN(HSL), .H_BACKPORCH(HBP),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNCLEN(VSL), .V_BACKPORCH(VBP),
    .SRC_H_ACTIVE(SH), .SRC_V_ACTIVE(SV), .X_REP(XR), .Y_REP(YR),
    .H_IMG_START(HIS), .V_IMG_START(VIS), .NUM_LINE_BUFFERS(NLB), .V_LOCK_LINE(VLK)
  ) dut (
    .PCLK_ext(PCLK_ext), .reset_n(reset_n), .frame_sync(frame_sync),
    .hcnt_ext(hcnt_ext), .vcnt_ext(vcnt_ext),
    .hcnt_ext_lbuf(hcnt_ext_lbuf), .vcnt_ext_lbuf(vcnt_ext_lbuf),
    .hctr_ext(hctr_ext), .vctr_ext(vctr_ext),
    .HSYNC_ext(HSYNC_ext), .VSYNC_ext(VSYNC_ext), .DE_ext(DE_ext),
    .img_en(img_en), .locked(locked)
  );

  always #5 PCLK_ext = ~PCLK_ext;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d pos=(%0d,%0d) t=%0t", tag, got, exp, mh, mv, $time);
    end
  endtask

  function automatic bit in_rng(input int x, input int lo, input int n);
    return (x >= lo) && (x < lo + n);
  endfunction

  task automatic model_reset();
    mh = HT - 1; mv = VT - 1; mpend = 1'b0; mlocked = 1'b0;
  endtask

  task automatic check_reset_vals();
    check_val("rst_hcnt", hcnt_ext, 0);
    check_val("rst_vcnt", vcnt_ext, 0);
    check_val("rst_hlbuf", hcnt_ext_lbuf, 0);
    check_val("rst_vlbuf", vcnt_ext_lbuf, 0);
    check_val("rst_hctr", hctr_ext, 0);
    check_val("rst_vctr", vctr_ext, 0);
    check_val("rst_hsync", HSYNC_ext, 1);
    check_val("rst_vsync", VSYNC_ext, 1);
    check_val("rst_de", DE_ext, 0);
    check_val("rst_img", img_en, 0);
    check_val("rst_locked", locked, 0);
  endtask

  task automatic check_outputs();
    bit ih, iv, im;
    ih = in_rng(mh, HIS, XR * SH);
    iv = in_rng(mv, VIS, YR * SV);
    im = ih && iv;
    check_val("hcnt", hcnt_ext, mh);
    check_val("vcnt", vcnt_ext, mv);
    check_val("hsync", HSYNC_ext, (mh < HSL) ? 0 : 1);
    check_val("vsync", VSYNC_ext, (mv < VSL) ? 0 : 1);
    check_val("de", DE_ext, (in_rng(mh, HSL + HBP, HA) && in_rng(mv, VSL + VBP, VA)) ? 1 : 0);
    check_val("img_en", img_en, im ? 1 : 0);
    check_val("hctr", hctr_ext, im ? (mh - HIS) % XR : 0);
    check_val("hlbuf", hcnt_ext_lbuf, im ? (mh - HIS) / XR : 0);
    check_val("vctr", vctr_ext, iv ? (mv - VIS) % YR : 0);
    check_val("vlbuf", vcnt_ext_lbuf, iv ? ((mv - VIS) / YR) % NLB : 0);
    check_val("locked", locked, mlocked ? 1 : 0);
  endtask

  // One clock: the model advances to the pixel the DUT should now present.
  task automatic step(input bit fs);
    int nat;
    frame_sync = fs;
    @(posedge PCLK_ext);
    cyc++;
    if (mh == HT - 1) begin
      mh  = 0;
      nat = (mv + 1) % VT;
      if (LOCK_ON && (mpend || fs)) begin
        mv = VLK; mlocked = (nat == VLK); mpend = 1'b0;
      end else begin
        mv = nat;
      end
    end else begin
      mh++;
      if (LOCK_ON && fs) mpend = 1'b1;
    end
    #1;
    frame_sync = 1'b0;
    check_outputs();
    if (DE_ext) de_cnt++;
    if (img_en) img_cnt++;
    if (!HSYNC_ext) hs_cnt++;
  endtask

  task automatic run_to(input int h, input int v);
    for (int i = 0; i < HT * VT + HT; i++) begin
      if (mh == h && mv == v) return;
      step(1'b0);
    end
    check_val("run_to_timeout", 0, 1);
  endtask

  initial begin
    reset_n = 1'b0; frame_sync = 1'b0;
    model_reset();
    #12;
    check_reset_vals();
    @(negedge PCLK_ext);
    reset_n = 1'b1;

    de_cnt = 0; img_cnt = 0; hs_cnt = 0;
    for (int i = 0; i < HT * VT; i++) step(1'b0);
    check_val("frame_de", de_cnt, HA * VA);
    check_val("frame_img", img_cnt, XR * SH * YR * SV);
    check_val("frame_hsync", hs_cnt, HSL * VT);
    check_val("frame_end_h", hcnt_ext, HT - 1);
    check_val("frame_end_v", vcnt_ext, VT - 1);

    // Jump to the lock line, then a pulse one frame later that needs no jump.
    run_to(10, 20);
    step(1'b1);
    c0 = cyc;
    run_to(HT - 1, 20);
    step(1'b0);
    check_val("jump_v", vcnt_ext, LOCK_ON ? VLK : 21);
    check_val("jump_locked", locked, 0);
    while (cyc < c0 + HT * VT - 1) step(1'b0);
    step(1'b1);
    for (int i = 0; i < HT - 10; i++) step(1'b0);
    check_val("relock_v", vcnt_ext, LOCK_ON ? 0 : 21);
    check_val("relock_locked", locked, LOCK_ON ? 1 : 0);

    // Two pulses inside one line produce a single load.
    run_to(5, 3);
    step(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0);
    step(1'b1);
    run_to(HT - 1, 3);
    step(1'b0);
    check_val("dbl_v", vcnt_ext, LOCK_ON ? VLK : 4);
    check_val("dbl_locked", locked, 0);
    run_to(HT - 1, LOCK_ON ? VLK : 4);
    step(1'b0);
    check_val("dbl_next_v", vcnt_ext, LOCK_ON ? VLK + 1 : 5);

    // Pulse on the wrap cycle loads on that same edge.
    run_to(HT - 1, 12);
    step(1'b1);
    check_val("coinc_v", vcnt_ext, LOCK_ON ? VLK : 13);

    for (int i = 0; i < 3 * HT * VT; i++)
      step(($urandom_range(0, 599) == 0) || (mh == HT - 1 && $urandom_range(0, 29) == 0));

    // Asynchronous reset mid-line, then restart from (0,0).
    run_to(20, 15);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    @(negedge PCLK_ext);
    reset_n = 1'b1;
    step(1'b0);
    check_val("restart_h", hcnt_ext, 0);
    check_val("restart_v", vcnt_ext, 0);
    for (int i = 0; i < HT * VT; i++)
      step($urandom_range(0, 799) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
